// File: rtl/riscv_pkg.sv
// Shared load/store definitions: access-size encodings, FSM states and
// the per-access context captured when a request is accepted.
package riscv_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // Load-return context kept for the whole access.
  typedef struct packed {
    size_e            size;
    logic [1:0]       off;
    logic             uns;
    logic [RD_W-1:0]  rd;
  } ld_ctx_t;

  // Decode the raw size field; the unused encoding 11 behaves as a word.
  function automatic size_e to_size(input logic [1:0] raw);
    case (raw)
      2'b01:   return SIZE_HALF;
      2'b10:   return SIZE_BYTE;
      default: return SIZE_WORD;
    endcase
  endfunction

  // Words need a 4-byte boundary, halves a 2-byte boundary, bytes never fault.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SIZE_WORD: return off != 2'b00;
      SIZE_HALF: return off[0];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface mem_lsu_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables and store replication for the
// request side, byte extraction and sign/zero extension for the load side.
module lsu_align
  import riscv_pkg::*;
(
  input  size_e             i_st_size,
  input  logic [1:0]        i_st_off,
  input  logic [DATA_W-1:0] i_wdata,
  input  size_e             i_ld_size,
  input  logic [1:0]        i_ld_off,
  input  logic              i_ld_unsigned,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [BE_W-1:0]   o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_load_data
);

  logic [DATA_W-1:0] w_shifted;

  // Bring the addressed byte lane down to bit 0.
  assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

  // Byte enables and lane-replicated store data.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_st_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        o_be    = 4'b0011 << i_st_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Truncate to access size and extend to a full register.
  always_comb begin
    o_load_data = w_shifted;
    case (i_ld_size)
      SIZE_BYTE: o_load_data = i_ld_unsigned ? {24'h0, w_shifted[7:0]}
                                             : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SIZE_HALF: o_load_data = i_ld_unsigned ? {16'h0, w_shifted[15:0]}
                                             : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: accepts one access at a time from decode, issues it on
// the data-memory bus and returns extended load data to writeback.
module mem_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_inst_size,
  input  logic              i_load_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [RD_W-1:0]   i_rd_in,
  output logic              o_stall,
  output logic              o_load_valid,
  output logic [DATA_W-1:0] o_load_data,
  output logic [RD_W-1:0]   o_load_rd,
  output logic              o_misaligned,
  mem_lsu_if.master         bus
);

  state_e            r_state;
  state_e            w_next;
  logic              w_capture;
  logic              w_stall;
  logic              w_load_valid;
  logic              w_misaligned;
  logic              w_access;
  logic              w_bad_align;
  size_e             w_size;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_load_data;

  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  ld_ctx_t           r_ctx;

  assign w_access    = i_mem_read | i_mem_write;
  assign w_size      = to_size(i_inst_size);
  assign w_bad_align = is_misaligned(w_size, i_addr[1:0]);

  lsu_align u_align (
    .i_st_size     (w_size),
    .i_st_off      (i_addr[1:0]),
    .i_wdata       (i_wdata),
    .i_ld_size     (r_ctx.size),
    .i_ld_off      (r_ctx.off),
    .i_ld_unsigned (r_ctx.uns),
    .i_rdata       (bus.dmem_rdata),
    .o_be          (w_be),
    .o_wdata       (w_wdata_rep),
    .o_load_data   (w_load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state, stall and pulse outputs; reset suppresses every pulse.
  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_stall      = 1'b0;
    w_load_valid = 1'b0;
    w_misaligned = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_bad_align) begin
              w_misaligned = 1'b1;
            end else begin
              w_capture = 1'b1;
              w_stall   = 1'b1;
              w_next    = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.dmem_gnt) begin
            if (r_we) begin
              w_next = ST_IDLE;
            end else begin
              w_stall = 1'b1;
              w_next  = ST_WAIT;
            end
          end else begin
            w_stall = 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.dmem_rvalid) begin
            w_load_valid = 1'b1;
            w_next       = ST_IDLE;
          end else begin
            w_stall = 1'b1;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Capture the whole access when it is accepted; stores win over loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_ctx   <= '0;
    end else if (w_capture) begin
      r_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
      r_be    <= w_be;
      r_we    <= i_mem_write;
      r_wdata <= w_wdata_rep;
      r_ctx   <= '{size: w_size, off: i_addr[1:0], uns: i_load_unsigned, rd: i_rd_in};
    end
  end

  // Bus side: request and qualifiers decoded from registered state only.
  assign bus.dmem_req   = (r_state == ST_REQ);
  assign bus.dmem_we    = (r_state == ST_REQ) & r_we;
  assign bus.dmem_be    = (r_state == ST_REQ) ? r_be : 4'b0000;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wdata = r_wdata;

  // Pipeline side.
  assign o_stall      = w_stall;
  assign o_load_valid = w_load_valid;
  assign o_load_data  = w_load_data;
  assign o_load_rd    = r_ctx.rd;
  assign o_misaligned = w_misaligned;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: the bench plays decode and data memory,
// expected bus beats and load results are queued up front and checked
// as the DUT produces them.
module tb_mem_lsu;
  import riscv_pkg::*;

  localparam int unsigned ADDR_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } ld_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, load_unsigned;
  logic [1:0]  inst_size;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_in;
  logic        stall, load_valid, misaligned;
  logic [31:0] load_data;
  logic [4:0]  load_rd;

  bus_exp_t bus_q[$];
  ld_exp_t  ld_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(ADDR_W)) u_bus ();

  mem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_mem_read      (mem_read),
    .i_mem_write     (mem_write),
    .i_inst_size     (inst_size),
    .i_load_unsigned (load_unsigned),
    .i_addr          (addr),
    .i_wdata         (wdata),
    .i_rd_in         (rd_in),
    .o_stall         (stall),
    .o_load_valid    (load_valid),
    .o_load_data     (load_data),
    .o_load_rd       (load_rd),
    .o_misaligned    (misaligned),
    .bus             (u_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_req"},   32'(u_bus.dmem_req), 32'd0);
    chk({tag, "_we"},    32'(u_bus.dmem_we), 32'd0);
    chk({tag, "_be"},    32'(u_bus.dmem_be), 32'd0);
    chk({tag, "_lv"},    32'(load_valid), 32'd0);
    chk({tag, "_mis"},   32'(misaligned), 32'd0);
  endtask

  // One access from decode; the memory grants after gnt_dly request cycles
  // and returns data after rv_dly wait cycles.
  task automatic run_access(input string name, input logic rd_i, input logic wr_i,
                            input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] rdi, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, input logic exp_mis,
                            input int exp_stalls, input int exp_total);
    int   n = 0, stalls = 0, req_cyc = 0, wait_cyc = 0;
    logic in_wait = 1'b0, done = 1'b0, saw_mis = 1'b0;
    bus_exp_t be_exp;
    ld_exp_t  ld_exp;
    @(negedge clk);
    reset = 1'b0; mem_read = rd_i; mem_write = wr_i; inst_size = sz;
    load_unsigned = uns; addr = a; wdata = wd; rd_in = rdi;
    while (!done && n < 64) begin
      if (n > 0) @(negedge clk);
      u_bus.dmem_gnt    = u_bus.dmem_req && (req_cyc == gnt_dly);
      u_bus.dmem_rvalid = in_wait && (wait_cyc == rv_dly);
      u_bus.dmem_rdata  = rdata;
      #1;
      n++;
      if (stall) stalls++;
      if (misaligned) saw_mis = 1'b1;
      if (u_bus.dmem_req) begin
        if (bus_q.size() == 0) begin
          chk({name, "_unexpected_req"}, 32'(u_bus.dmem_req), 32'd0);
        end else begin
          be_exp = bus_q[0];
          chk({name, "_addr"}, u_bus.dmem_addr, be_exp.addr);
          chk({name, "_be"},   32'(u_bus.dmem_be), 32'(be_exp.be));
          chk({name, "_we"},   32'(u_bus.dmem_we), 32'(be_exp.we));
          if (be_exp.we) chk({name, "_wdata"}, u_bus.dmem_wdata, be_exp.wdata);
          if (u_bus.dmem_gnt) void'(bus_q.pop_front());
        end
      end
      if (load_valid) begin
        if (ld_q.size() == 0) begin
          chk({name, "_unexpected_lv"}, 32'(load_valid), 32'd0);
        end else begin
          ld_exp = ld_q.pop_front();
          chk({name, "_ldata"}, load_data, ld_exp.data);
          chk({name, "_ldrd"},  32'(load_rd), 32'(ld_exp.rd));
        end
      end
      if (u_bus.dmem_rvalid) in_wait = 1'b0;
      else if (in_wait) wait_cyc++;
      if (u_bus.dmem_req) begin
        if (u_bus.dmem_gnt) in_wait = !wr_i;
        else req_cyc++;
      end
      done = !stall;
    end
    if (!done) chk({name, "_timeout"}, 32'(done), 32'd1);
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({name, "_total_cycles"}, 32'(n), 32'(exp_total));
    chk({name, "_mis_pulse"},    32'(saw_mis), 32'(exp_mis));
    chk({name, "_bus_q_left"},   32'(bus_q.size()), 32'd0);
    chk({name, "_ld_q_left"},    32'(ld_q.size()), 32'd0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    u_bus.dmem_gnt = 1'b0; u_bus.dmem_rvalid = 1'b0;
    #1;
    chk_idle({name, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; inst_size = 2'b00;
    load_unsigned = 1'b0; addr = '0; wdata = '0; rd_in = '0;
    u_bus.dmem_gnt = 1'b0; u_bus.dmem_rvalid = 1'b0; u_bus.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset_load_rd", 32'(load_rd), 32'd0);
    chk("reset_addr",    u_bus.dmem_addr, 32'd0);

    // SW straight out of reset, granted at once.
    bus_q.push_back('{32'h0000_0104, 4'b1111, 1'b1, 32'hDEAD_BEEF});
    run_access("sw", 1'b0, 1'b1, 2'b00, 1'b0, 32'h104, 32'hDEAD_BEEF, 5'd0,
               0, 0, 32'h0, 1'b0, 1, 2);

    // SB to the top lane with grant delayed three cycles.
    bus_q.push_back('{32'h0000_0100, 4'b1000, 1'b1, 32'hA5A5_A5A5});
    run_access("sb", 1'b0, 1'b1, 2'b10, 1'b0, 32'h103, 32'h0000_00A5, 5'd0,
               3, 0, 32'h0, 1'b0, 4, 5);

    // LB / LBU on lane 2, data two cycles after grant.
    bus_q.push_back('{32'h0000_0200, 4'b0100, 1'b0, 32'h0});
    ld_q.push_back('{32'hFFFF_FFF0, 5'd5});
    run_access("lb", 1'b1, 1'b0, 2'b10, 1'b0, 32'h202, 32'h0, 5'd5,
               0, 1, 32'h12F0_3456, 1'b0, 3, 4);
    bus_q.push_back('{32'h0000_0200, 4'b0100, 1'b0, 32'h0});
    ld_q.push_back('{32'h0000_00F0, 5'd6});
    run_access("lbu", 1'b1, 1'b0, 2'b10, 1'b1, 32'h202, 32'h0, 5'd6,
               0, 1, 32'h12F0_3456, 1'b0, 3, 4);

    // Alignment faults: no request, no stall.
    run_access("lh_mis", 1'b1, 1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 5'd3,
               0, 0, 32'h0, 1'b1, 0, 1);
    run_access("lw_mis", 1'b1, 1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 5'd3,
               0, 0, 32'h0, 1'b1, 0, 1);
    run_access("sw_mis", 1'b0, 1'b1, 2'b00, 1'b0, 32'h105, 32'h1111_2222, 5'd0,
               0, 0, 32'h0, 1'b1, 0, 1);

    // LHU on the upper half at minimum latency.
    bus_q.push_back('{32'h0000_0300, 4'b1100, 1'b0, 32'h0});
    ld_q.push_back('{32'h0000_8001, 5'd9});
    run_access("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 5'd9,
               0, 0, 32'h8001_ABCD, 1'b0, 2, 3);

    // Read and write together behaves as a store (SH upper half).
    bus_q.push_back('{32'h0000_0104, 4'b1100, 1'b1, 32'hBEEF_BEEF});
    run_access("sh_rw", 1'b1, 1'b1, 2'b01, 1'b0, 32'h106, 32'h1234_BEEF, 5'd4,
               0, 0, 32'h0, 1'b0, 1, 2);

    // Size 11 decodes as word.
    bus_q.push_back('{32'h0000_0208, 4'b1111, 1'b0, 32'h0});
    ld_q.push_back('{32'hCAFE_F00D, 5'd12});
    run_access("lw_sz3", 1'b1, 1'b0, 2'b11, 1'b1, 32'h208, 32'h0, 5'd12,
               1, 2, 32'hCAFE_F00D, 1'b0, 5, 6);

    // Stray rvalid while idle is ignored.
    @(negedge clk);
    u_bus.dmem_rvalid = 1'b1; u_bus.dmem_rdata = 32'h5555_AAAA;
    #1;
    chk_idle("rvalid_idle");

    // Reset during WAIT abandons the load.
    @(negedge clk);
    u_bus.dmem_rvalid = 1'b0;
    mem_read = 1'b1; inst_size = 2'b00; load_unsigned = 1'b0;
    addr = 32'h400; rd_in = 5'd7;
    #1;
    chk("rst_wait_accept_stall", 32'(stall), 32'd1);
    @(negedge clk);
    u_bus.dmem_gnt = 1'b1;
    #1;
    chk("rst_wait_req", 32'(u_bus.dmem_req), 32'd1);
    @(negedge clk);
    u_bus.dmem_gnt = 1'b0;
    #1;
    chk("rst_wait_stall", 32'(stall), 32'd1);
    chk("rst_wait_noreq", 32'(u_bus.dmem_req), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0;
    u_bus.dmem_rvalid = 1'b1; u_bus.dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk_idle("rst_wait_post");
    chk("rst_wait_load_rd", 32'(load_rd), 32'd0);
    @(negedge clk);
    u_bus.dmem_rvalid = 1'b0;
    #1;
    chk_idle("rst_wait_post2");

    // The unit is usable again right after the abandoned access.
    bus_q.push_back('{32'h0000_0500, 4'b0010, 1'b1, 32'h3C3C_3C3C});
    run_access("sb_after_rst", 1'b0, 1'b1, 2'b10, 1'b0, 32'h501, 32'h0000_003C, 5'd0,
               1, 0, 32'h0, 1'b0, 2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
